// File: rtl/delaychain_sampler.sv
// delaychain_sampler: launches edges into a tapped delay chain, captures and averages tap counts.
// Result (sum of 2^AVG_LOG2 popcounts plus sticky bubble/overflow flags) is held on a valid/ready port.
module delaychain_sampler #(
   parameter int TAPS     = 32,
   parameter int AVG_LOG2 = 3,
   parameter int SETTLE   = 4,
   parameter int CNT_W    = $clog2(TAPS + 1),
   parameter int RES_W    = CNT_W + AVG_LOG2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [TAPS-1:0]  taps,
   output logic             launch,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] out_sum,
   output logic             out_bubble,
   output logic             out_ovf
);
   localparam int SW = $clog2(SETTLE + 1);
   localparam int IW = AVG_LOG2 + 1;
   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_HOLD, S_ACCUM, S_SETTLE, S_DONE} state_t;
   state_t            r_state, w_next;
   logic [TAPS-1:0]   r_cap, r_sync;
   logic [RES_W-1:0]  r_acc;
   logic [IW-1:0]     r_idx;
   logic [SW-1:0]     r_set;
   logic              r_launch, r_bubble, r_ovf;
   logic [CNT_W-1:0]  w_cnt;
   logic              w_last_set, w_last_idx, w_bubble, w_ovf;
   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < TAPS; i++) w_cnt = w_cnt + CNT_W'(r_sync[i]);
   end
   // a clean thermometer code plus one is a power of two, so any overlap means a bubble
   assign w_bubble   = |(r_sync & (r_sync + TAPS'(1)));
   assign w_ovf      = &r_sync;
   assign w_last_set = r_set == SW'(SETTLE - 1);
   assign w_last_idx = r_idx == IW'(2 ** AVG_LOG2 - 1);
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = start ? S_LAUNCH : S_IDLE;
         S_LAUNCH: w_next = S_HOLD;
         S_HOLD:   w_next = S_ACCUM;
         S_ACCUM:  w_next = S_SETTLE;
         S_SETTLE: w_next = w_last_set ? (w_last_idx ? S_DONE : S_LAUNCH) : S_SETTLE;
         S_DONE:   w_next = out_ready ? S_IDLE : S_DONE;
         default:  w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_launch <= 1'b0;
         r_cap    <= '0;
         r_sync   <= '0;
         r_acc    <= '0;
         r_idx    <= '0;
         r_set    <= '0;
         r_bubble <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_launch <= w_next == S_LAUNCH;
         r_set    <= (r_state == S_SETTLE && !w_last_set) ? r_set + SW'(1) : '0;
         if (r_state == S_IDLE && start) begin
            r_acc    <= '0;
            r_idx    <= '0;
            r_bubble <= 1'b0;
            r_ovf    <= 1'b0;
         end
         if (r_state == S_LAUNCH) r_cap <= taps;
         if (r_state == S_HOLD) r_sync <= r_cap;
         if (r_state == S_ACCUM) begin
            r_acc    <= r_acc + RES_W'(w_cnt);
            r_bubble <= r_bubble | w_bubble;
            r_ovf    <= r_ovf | w_ovf;
         end
         if (r_state == S_SETTLE && w_last_set && !w_last_idx) r_idx <= r_idx + IW'(1);
      end
   end
   assign launch     = r_launch;
   assign busy       = r_state != S_IDLE;
   assign out_valid  = r_state == S_DONE;
   assign out_sum    = r_acc;
   assign out_bubble = r_bubble;
   assign out_ovf    = r_ovf;
endmodule

// File: tb/tb_delaychain_sampler.sv
// tb_delaychain_sampler: randomized runs scored against a popcount/thermometer reference model.
// Expected results are queued at start; a monitor pops them when out_valid rises.
module tb_delaychain_sampler;
   logic        clk = 0, rst = 1, start = 0, out_ready = 1;
   logic [31:0] taps = 0;
   logic        launch, busy, out_valid, out_bubble, out_ovf;
   logic [8:0]  out_sum;
   typedef struct {int sum; bit bub; bit ovf; int rise;} exp_t;
   exp_t        q[$];
   logic [31:0] pat[8];
   int          cyc = 0, lcnt = 0, e0 = -1000, total = 0, bad = 0;

   delaychain_sampler dut (
      .clk(clk), .rst(rst), .start(start), .taps(taps), .launch(launch), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_bubble(out_bubble), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string n, int act, int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] therm(int n);
      logic [32:0] t = (33'd1 << n) - 33'd1;
      return t[31:0];
   endfunction

   function automatic exp_t model(int rise);
      exp_t e;
      e.sum = 0; e.bub = 0; e.ovf = 0; e.rise = rise;
      foreach (pat[k]) begin
         int n = $countones(pat[k]);
         e.sum += n;
         if (pat[k] !== therm(n)) e.bub = 1;
         if (n == 32) e.ovf = 1;
      end
      return e;
   endfunction

   // chain model: presents the current pattern while launch is high, noise otherwise
   initial forever begin
      @(negedge clk);
      if (launch) begin
         taps = pat[lcnt % 8];
         lcnt++;
      end else taps = $urandom;
   end

   initial begin
      exp_t cur;
      bit pv, pr;
      pv = 0; pr = 0;
      cur.sum = 0; cur.bub = 0; cur.ovf = 0; cur.rise = 0;
      forever begin
         @(negedge clk); #1;
         if (launch) chk("launch_phase", int'((cyc - e0) % 7 == 0 && cyc - e0 < 56), 1);
         if (out_valid && !pv) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_result got sum=%0d want no result", out_sum);
            end else begin
               cur = q.pop_front();
               chk("sum", int'(out_sum), cur.sum);
               chk("bubble", int'(out_bubble), int'(cur.bub));
               chk("ovf", int'(out_ovf), int'(cur.ovf));
               chk("valid_rise_cycle", cyc, cur.rise);
            end
         end else if (out_valid && pv && !pr) begin
            chk("hold_outputs", int'({out_sum, out_bubble, out_ovf}), (cur.sum << 2) | (int'(cur.bub) << 1) | int'(cur.ovf));
            chk("hold_busy", int'(busy), 1);
         end else if (pv && pr) chk("valid_drop", int'(out_valid), 0);
         pv = out_valid; pr = out_ready;
      end
   end

   task automatic go(bit push);
      @(negedge clk);
      lcnt = 0;
      start = 1;
      @(negedge clk);
      start = 0;
      e0 = cyc;
      if (push) q.push_back(model(cyc + 56));
   endtask

   task automatic finish_run(int hold, bit st);
      int n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("valid_timeout", n, 0);
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         out_ready = 1;
         start = st;
         @(negedge clk);
         out_ready = 0;
         start = 0;
      end else @(negedge clk);
      chk("idle_after", int'({busy, out_valid}), 0);
      if (st) begin
         repeat (4) @(negedge clk);
         chk("no_restart", int'(busy), 0);
      end
   endtask

   task automatic chk_zero(string n);
      chk({n, "_launch"}, int'(launch), 0);
      chk({n, "_busy"}, int'(busy), 0);
      chk({n, "_valid"}, int'(out_valid), 0);
      chk({n, "_sum"}, int'(out_sum), 0);
      chk({n, "_bubble"}, int'(out_bubble), 0);
      chk({n, "_ovf"}, int'(out_ovf), 0);
   endtask

   initial begin
      int h, r;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 0;
      // abort during the third settle cycle of sample 2
      foreach (pat[k]) pat[k] = therm($urandom_range(1, 31));
      go(0);
      while (cyc < e0 + 19) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk_zero("midrun_reset");
      rst = 0;
      foreach (pat[k]) pat[k] = 32'h0000_0FFF;
      go(1);
      finish_run(0, 0);
      foreach (pat[k]) pat[k] = therm(k);
      go(1);
      while (cyc < e0 + 20) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      finish_run(0, 0);
      foreach (pat[k]) pat[k] = 32'h0000_00FF;
      pat[$urandom_range(0, 7)] = 32'h0000_00F7;
      go(1);
      finish_run(0, 0);
      foreach (pat[k]) pat[k] = therm($urandom_range(0, 31));
      pat[$urandom_range(0, 7)] = 32'hFFFF_FFFF;
      go(1);
      finish_run(0, 0);
      out_ready = 0;
      foreach (pat[k]) pat[k] = therm($urandom_range(0, 32));
      go(1);
      finish_run(20, 1);
      out_ready = 1;
      foreach (pat[k]) pat[k] = 32'hFFFF_FFFF;
      go(1);
      finish_run(0, 0);
      repeat (4) begin
         foreach (pat[k]) begin
            r = $urandom_range(0, 1);
            pat[k] = r ? $urandom : therm($urandom_range(0, 32));
         end
         h = $urandom_range(0, 3);
         out_ready = (h == 0);
         go(1);
         finish_run(h, 0);
         out_ready = 1;
      end
      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
